// File: rtl/game_ctrl_multi.sv
// game_ctrl_multi: top-level game flow controller.
// Sequences INITIAL -> START -> PLAY and the PLAY side states (COLLISION,
// BOMB, CLEAR), ending in SUCCESS or GAMEOVER. Tracks lives, bombs and the
// current stage, and emits a one-cycle game_reset on every (re)start of play.
//
// Optional feature: define GAME_CTRL_PAUSE_EN to let an enter press in PLAY
// freeze the game in PAUSE until the next enter press. Without the macro,
// PAUSE is unreachable and enter is ignored in PLAY.
//
// Handshake note: there is no valid/ready traffic here. enter and bomb are
// level inputs whose rising edges count as presses; collision and die are
// acted on at every cycle they are high in a state that listens to them.
// game_state is the FSM state register, exposed for debug and checkers.
module game_ctrl_multi #(
  parameter int LIFE_INIT     = 3,
  parameter int BOMB_INIT     = 3,
  parameter int CNT_W         = 4,
  parameter int INIT_WAIT     = 20000000,
  parameter int INVULN_CYCLES = 200000000,
  parameter int BOMB_CYCLES   = 400000000,
  parameter int CLEAR_CYCLES  = 100000000,
  parameter int NUM_STAGES    = 3
) (
  input  logic             clk,
  input  logic             hard_reset_n,
  input  logic             enter,
  input  logic             bomb,
  input  logic             collision,
  input  logic             die,
  output logic [CNT_W-1:0] num_life,
  output logic [CNT_W-1:0] num_bomb,
  output logic [3:0]       game_state,
  output logic [3:0]       stage,
  output logic             game_en,
  output logic             game_reset
);

  // One shared down-counter, wide enough for the longest timed state.
  localparam int MAX_A   = (INIT_WAIT > INVULN_CYCLES) ? INIT_WAIT : INVULN_CYCLES;
  localparam int MAX_B   = (BOMB_CYCLES > CLEAR_CYCLES) ? BOMB_CYCLES : CLEAR_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [3:0] {
    ST_INITIAL   = 4'b0000,
    ST_START     = 4'b0001,
    ST_PLAY      = 4'b0010,
    ST_PAUSE     = 4'b0011,
    ST_CLEAR     = 4'b0100,
    ST_BOMB      = 4'b0110,
    ST_SUCCESS   = 4'b1000,
    ST_GAMEOVER  = 4'b1001,
    ST_COLLISION = 4'b1010
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [CNT_W-1:0]  life_n, bomb_n;
  logic [3:0]        stage_n;
  logic              en_n, pulse_n;
  logic              enter_q, bomb_q;
  logic              enter_rise, bomb_rise;
  logic              timer_done;
  logic [TW-1:0]     timer_dec;
  logic              last_stage;
  state_t            die_target;

  assign enter_rise = enter & ~enter_q;
  assign bomb_rise  = bomb & ~bomb_q;
  // A timed state ends on the cycle its counter shows 1, giving exactly N cycles.
  assign timer_done = (timer <= TW'(1));
  assign timer_dec  = timer - TW'(1);
  assign last_stage = (stage >= 4'(NUM_STAGES - 1));
  assign die_target = last_stage ? ST_SUCCESS : ST_CLEAR;
  assign game_state = state;

  // State, counters, registered outputs and button history.
  always_ff @(posedge clk) begin
    if (!hard_reset_n) begin
      state      <= ST_INITIAL;
      timer      <= TW'(INIT_WAIT);
      num_life   <= CNT_W'(LIFE_INIT);
      num_bomb   <= CNT_W'(BOMB_INIT);
      stage      <= 4'd0;
      game_en    <= 1'b0;
      game_reset <= 1'b0;
      enter_q    <= 1'b0;
      bomb_q     <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      num_life   <= life_n;
      num_bomb   <= bomb_n;
      stage      <= stage_n;
      game_en    <= en_n;
      game_reset <= pulse_n;
      enter_q    <= enter;
      bomb_q     <= bomb;
    end
  end

  // Next-state, counter updates and next values of the registered outputs.
  always_comb begin
    state_n = state;
    timer_n = timer;
    life_n  = num_life;
    bomb_n  = num_bomb;
    stage_n = stage;
    pulse_n = 1'b0;
    case (state)
      ST_INITIAL: begin
        if (timer_done) state_n = ST_START;
        else            timer_n = timer_dec;
      end
      ST_START: begin
        if (enter_rise) begin
          state_n = ST_PLAY;
          stage_n = 4'd0;
          life_n  = CNT_W'(LIFE_INIT);
          bomb_n  = CNT_W'(BOMB_INIT);
          pulse_n = 1'b1;
        end
      end
      ST_PLAY: begin
        if (die) begin
          state_n = die_target;
          timer_n = TW'(CLEAR_CYCLES);
        end else if (collision) begin
          if (num_life > CNT_W'(1)) begin
            life_n  = num_life - CNT_W'(1);
            state_n = ST_COLLISION;
            timer_n = TW'(INVULN_CYCLES);
          end else begin
            // Clamp at zero so the life count can never wrap.
            life_n  = '0;
            state_n = ST_GAMEOVER;
          end
        end else if (bomb_rise && (num_bomb != '0)) begin
          bomb_n  = num_bomb - CNT_W'(1);
          state_n = ST_BOMB;
          timer_n = TW'(BOMB_CYCLES);
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (enter_rise) begin
          state_n = ST_PAUSE;
        end
`endif
      end
      ST_COLLISION: begin
        if (die) begin
          state_n = die_target;
          timer_n = TW'(CLEAR_CYCLES);
        end else if (bomb_rise && (num_bomb != '0)) begin
          bomb_n  = num_bomb - CNT_W'(1);
          state_n = ST_BOMB;
          timer_n = TW'(BOMB_CYCLES);
        end else if (timer_done) begin
          state_n = ST_PLAY;
        end else begin
          timer_n = timer_dec;
        end
      end
      ST_BOMB: begin
        if (die) begin
          state_n = die_target;
          timer_n = TW'(CLEAR_CYCLES);
        end else if (timer_done) begin
          state_n = ST_PLAY;
        end else begin
          timer_n = timer_dec;
        end
      end
      ST_CLEAR: begin
        if (timer_done) begin
          state_n = ST_PLAY;
          stage_n = stage + 4'd1;
          bomb_n  = CNT_W'(BOMB_INIT);
          pulse_n = 1'b1;
        end else begin
          timer_n = timer_dec;
        end
      end
      ST_SUCCESS, ST_GAMEOVER: begin
        if (enter_rise) begin
          state_n = ST_INITIAL;
          timer_n = TW'(INIT_WAIT);
          life_n  = CNT_W'(LIFE_INIT);
          bomb_n  = CNT_W'(BOMB_INIT);
          stage_n = 4'd0;
          pulse_n = 1'b1;
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: begin
        // Everything frozen; only an enter press resumes play.
        if (enter_rise) state_n = ST_PLAY;
      end
`endif
      default: begin
        state_n = ST_INITIAL;
        timer_n = TW'(INIT_WAIT);
      end
    endcase
    en_n = (state_n == ST_PLAY) || (state_n == ST_COLLISION) || (state_n == ST_BOMB);
  end

endmodule

// File: tb/tb_game_ctrl_multi.sv
// tb_game_ctrl_multi: directed scenarios followed by random play, with every
// cycle compared against a rule-level reference model of the game flow.
module tb_game_ctrl_multi;

  localparam int LIFE  = 3;
  localparam int BOMBS = 3;
  localparam int IW    = 4;
  localparam int INV   = 8;
  localparam int BC    = 6;
  localparam int CC    = 5;
  localparam int NST   = 2;
`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // Mode codes as seen on game_state.
  localparam logic [3:0] M_INIT = 4'd0, M_START = 4'd1, M_PLAY = 4'd2, M_PAUSE = 4'd3,
                         M_CLEAR = 4'd4, M_BOMB = 4'd6, M_WIN = 4'd8, M_LOSE = 4'd9,
                         M_HIT = 4'd10;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       hard_reset_n = 1'b0;
  logic       enter = 1'b0, bomb = 1'b0, collision = 1'b0, die = 1'b0;
  logic [3:0] num_life, num_bomb, game_state, stage;
  logic       game_en, game_reset;

  always #5 clk = ~clk;

  game_ctrl_multi #(
    .LIFE_INIT(LIFE), .BOMB_INIT(BOMBS), .CNT_W(4), .INIT_WAIT(IW),
    .INVULN_CYCLES(INV), .BOMB_CYCLES(BC), .CLEAR_CYCLES(CC), .NUM_STAGES(NST)
  ) dut (
    .clk(clk), .hard_reset_n(hard_reset_n), .enter(enter), .bomb(bomb),
    .collision(collision), .die(die), .num_life(num_life), .num_bomb(num_bomb),
    .game_state(game_state), .stage(stage), .game_en(game_en), .game_reset(game_reset)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [3:0] m_mode;
  int         m_left;   // cycles still to spend in the current timed mode
  int         m_life, m_bombs, m_stage;
  bit         m_pulse;
  bit         prev_enter, prev_bomb;

  task automatic boss_killed();
    if (m_stage + 1 < NST) begin
      m_mode = M_CLEAR;
      m_left = CC;
    end else begin
      m_mode = M_WIN;
    end
  endtask

  task automatic model_step();
    bit pressed_enter, pressed_bomb;
    if (!hard_reset_n) begin
      m_mode = M_INIT; m_left = IW; m_life = LIFE; m_bombs = BOMBS; m_stage = 0;
      m_pulse = 0; prev_enter = 0; prev_bomb = 0;
      return;
    end
    pressed_enter = enter && !prev_enter;
    pressed_bomb  = bomb && !prev_bomb;
    prev_enter = enter;
    prev_bomb  = bomb;
    m_pulse = 0;
    case (m_mode)
      M_INIT: begin
        m_left--;
        if (m_left == 0) m_mode = M_START;
      end
      M_START: if (pressed_enter) begin
        m_mode = M_PLAY; m_life = LIFE; m_bombs = BOMBS; m_stage = 0; m_pulse = 1;
      end
      M_PLAY: begin
        if (die) boss_killed();
        else if (collision) begin
          if (m_life > 1) begin m_life--; m_mode = M_HIT; m_left = INV; end
          else begin m_life = 0; m_mode = M_LOSE; end
        end else if (pressed_bomb && m_bombs > 0) begin
          m_bombs--; m_mode = M_BOMB; m_left = BC;
        end else if (pressed_enter && PAUSE_EN) m_mode = M_PAUSE;
      end
      M_HIT: begin
        if (die) boss_killed();
        else if (pressed_bomb && m_bombs > 0) begin
          m_bombs--; m_mode = M_BOMB; m_left = BC;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_PLAY;
        end
      end
      M_BOMB: begin
        if (die) boss_killed();
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_PLAY;
        end
      end
      M_CLEAR: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_PLAY; m_stage++; m_bombs = BOMBS; m_pulse = 1;
        end
      end
      M_WIN, M_LOSE: if (pressed_enter) begin
        m_mode = M_INIT; m_left = IW; m_life = LIFE; m_bombs = BOMBS; m_stage = 0; m_pulse = 1;
      end
      M_PAUSE: if (pressed_enter) m_mode = M_PLAY;
      default: m_mode = M_INIT;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    chk(tag, obs);
  endtask

  // ---------------- driver ----------------
  // One clock: model and DUT both see the same inputs at the edge, outputs
  // are compared 1ns later.
  task automatic cyc();
    bit en_exp;
    @(posedge clk);
    model_step();
    #1;
    en_exp = (m_mode == M_PLAY) || (m_mode == M_HIT) || (m_mode == M_BOMB);
    exp_q.push_back(32'(m_mode));   chk("state", 32'(game_state));
    exp_q.push_back(32'(m_life));   chk("life", 32'(num_life));
    exp_q.push_back(32'(m_bombs));  chk("bombs", 32'(num_bomb));
    exp_q.push_back(32'(m_stage));  chk("stage", 32'(stage));
    exp_q.push_back(32'(en_exp));   chk("game_en", 32'(game_en));
    exp_q.push_back(32'(m_pulse));  chk("game_reset", 32'(game_reset));
  endtask

  task automatic press_enter();
    enter = 1'b1; cyc(); enter = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with enter held through release.
    hard_reset_n = 1'b0; enter = 1'b1;
    repeat (3) cyc();
    chk_const("rst_state", 32'(game_state), 32'd0);
    chk_const("rst_life", 32'(num_life), 32'd3);
    chk_const("rst_bomb", 32'(num_bomb), 32'd3);
    chk_const("rst_en", 32'(game_en), 32'd0);
    chk_const("rst_pulse", 32'(game_reset), 32'd0);
    hard_reset_n = 1'b1;
    repeat (3) cyc();
    chk_const("still_initial", 32'(game_state), 32'd0);
    cyc();
    chk_const("start_after_4", 32'(game_state), 32'd1);
    repeat (3) cyc();
    chk_const("held_enter_no_play", 32'(game_state), 32'd1);
    enter = 1'b0; cyc();
    press_enter();
    chk_const("play_entered", 32'(game_state), 32'd2);
    chk_const("start_pulse", 32'(game_reset), 32'd1);
    cyc();
    chk_const("pulse_single", 32'(game_reset), 32'd0);

    // Four bomb presses, each after the bomb period ends.
    for (int k = 0; k < 4; k++) begin
      bomb = 1'b1; cyc(); bomb = 1'b0;
      chk_const("bomb_count", 32'(num_bomb), (k < 3) ? 32'(2 - k) : 32'd0);
      chk_const("bomb_state", 32'(game_state), (k < 3) ? 32'd6 : 32'd2);
      repeat (7) cyc();
    end

    // die and collision together at stage 0: CLEAR, lives untouched.
    die = 1'b1; collision = 1'b1; cyc(); die = 1'b0; collision = 1'b0;
    chk_const("clear_state", 32'(game_state), 32'd4);
    chk_const("clear_life", 32'(num_life), 32'd3);
    chk_const("clear_en", 32'(game_en), 32'd0);
    repeat (4) cyc();
    chk_const("clear_hold", 32'(game_state), 32'd4);
    cyc();
    chk_const("clear_to_play", 32'(game_state), 32'd2);
    chk_const("stage_inc", 32'(stage), 32'd1);
    chk_const("bomb_reload", 32'(num_bomb), 32'd3);
    chk_const("clear_pulse", 32'(game_reset), 32'd1);
    cyc();

    // Enter during PLAY: pause if built in, otherwise ignored.
    press_enter();
    if (PAUSE_EN) begin
      chk_const("pause_state", 32'(game_state), 32'd3);
      chk_const("pause_en", 32'(game_en), 32'd0);
      collision = 1'b1; cyc(); collision = 1'b0;
      chk_const("pause_no_hit", 32'(num_life), 32'd3);
      cyc();
      press_enter();
      chk_const("unpause", 32'(game_state), 32'd2);
    end else begin
      chk_const("enter_ignored", 32'(game_state), 32'd2);
    end
    cyc();

    // Boss killed on the last stage.
    die = 1'b1; cyc(); die = 1'b0;
    chk_const("success", 32'(game_state), 32'd8);
    cyc();
    press_enter();
    chk_const("restart_init", 32'(game_state), 32'd0);
    chk_const("restart_pulse", 32'(game_reset), 32'd1);
    chk_const("restart_stage", 32'(stage), 32'd0);
    repeat (4) cyc();
    press_enter();

    // Three collisions, each after invulnerability ends.
    for (int k = 0; k < 3; k++) begin
      collision = 1'b1; cyc(); collision = 1'b0;
      chk_const("life_count", 32'(num_life), 32'(2 - k));
      repeat (9) cyc();
    end
    chk_const("gameover", 32'(game_state), 32'd9);
    chk_const("gameover_en", 32'(game_en), 32'd0);

    // Reset during a timed state leaves no pending pulse.
    press_enter();
    repeat (4) cyc();
    press_enter();
    bomb = 1'b1; cyc(); bomb = 1'b0;
    repeat (2) cyc();
    hard_reset_n = 1'b0; cyc();
    chk_const("abort_state", 32'(game_state), 32'd0);
    chk_const("abort_pulse", 32'(game_reset), 32'd0);
    hard_reset_n = 1'b1; cyc();
    chk_const("abort_no_pulse_after", 32'(game_reset), 32'd0);

    // Random play.
    for (int i = 0; i < 1500; i++) begin
      enter        = ($urandom_range(0, 3) == 0);
      bomb         = ($urandom_range(0, 4) == 0);
      collision    = ($urandom_range(0, 19) == 0);
      die          = ($urandom_range(0, 39) == 0);
      hard_reset_n = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl_multi.md
GAME_CTRL_MULTI -- requirements
Module: game_ctrl_multi

Interface
REQ-001 SHALL have parameter LIFE_INIT, default 3: lives loaded at game start.
REQ-002 SHALL have parameter BOMB_INIT, default 3: bombs loaded at game start and at each stage start.
REQ-003 SHALL have parameter CNT_W, default 4: width of num_life and num_bomb.
REQ-004 SHALL have parameter INIT_WAIT, default 20000000: cycles spent in INITIAL.
REQ-005 SHALL have parameter INVULN_CYCLES, default 200000000: cycles spent in COLLISION.
REQ-006 SHALL have parameter BOMB_CYCLES, default 400000000: cycles spent in BOMB.
REQ-007 SHALL have parameter CLEAR_CYCLES, default 100000000: cycles spent in CLEAR.
REQ-008 SHALL have parameter NUM_STAGES, default 3: stage count, 1..16.
REQ-009 SHALL have ports clk in 1 (clock), hard_reset_n in 1 (synchronous active-low reset).
REQ-010 SHALL have ports enter in 1 and bomb in 1: level-sensitive buttons, already synchronised to clk.
REQ-011 SHALL have ports collision in 1 (player hit) and die in 1 (boss killed).
REQ-012 SHALL have outputs num_life CNT_W, num_bomb CNT_W, game_state 4, stage 4, game_en 1 and game_reset 1; all registered.

Function
REQ-013 SHALL use the state encodings INITIAL=0000, START=0001, PLAY=0010, PAUSE=0011, CLEAR=0100, BOMB=0110, SUCCESS=1000, GAMEOVER=1001 and COLLISION=1010, and drive game_state with the current state.
REQ-014 SHALL detect rising edges on enter and bomb using previous-cycle registers; every "press" below means a rising edge.
REQ-015 SHALL use one down-counter, sized with $clog2 of the largest cycle parameter plus 1; a timed state SHALL last exactly its parameter's cycles, then take its exit transition.
REQ-016 INITIAL: after INIT_WAIT cycles SHALL go to START.
REQ-017 START: enter press SHALL go to PLAY, load stage=0, num_life=LIFE_INIT and num_bomb=BOMB_INIT, and pulse game_reset.
REQ-018 PLAY priority is die > collision > bomb press > enter press.
REQ-019 die SHALL go to CLEAR if stage<NUM_STAGES-1, else to SUCCESS.
REQ-020 collision with num_life>1 SHALL decrement num_life and go to COLLISION.
REQ-021 collision with num_life<=1 SHALL set num_life=0 and go to GAMEOVER; num_life SHALL never wrap.
REQ-022 bomb press with num_bomb>0 SHALL decrement num_bomb and go to BOMB; with num_bomb=0 the press SHALL be ignored.
REQ-023 COLLISION: die SHALL act as in REQ-019; a bomb press with num_bomb>0 SHALL decrement num_bomb and go to BOMB with a fresh BOMB_CYCLES count; collision SHALL be ignored; on timeout SHALL return to PLAY.
REQ-024 BOMB: die SHALL act as in REQ-019; collision and bomb SHALL be ignored; on timeout SHALL return to PLAY.
REQ-025 CLEAR: game_en=0; on timeout SHALL increment stage, reload num_bomb=BOMB_INIT, keep num_life, pulse game_reset and go to PLAY.
REQ-026 SUCCESS/GAMEOVER: enter press SHALL go to INITIAL, reload num_life and num_bomb, clear stage and pulse game_reset.
REQ-027 game_en SHALL be 1 in PLAY, COLLISION and BOMB, and 0 in all other states, taking effect the same cycle game_state changes.
REQ-028 game_reset SHALL be a single-cycle pulse registered with the transition; it SHALL never be asserted for two consecutive cycles.

Reset
REQ-029 On hard_reset_n=0 at a clk edge: state=INITIAL, timer=INIT_WAIT, num_life=LIFE_INIT, num_bomb=BOMB_INIT, stage=0, game_en=0, game_reset=0 and edge registers=0.
REQ-030 Reset mid-operation SHALL abort any timed state with no pending pulse.
REQ-031 A button held through reset release SHALL NOT register as a press.

Configuration
REQ-032 Macro GAME_CTRL_PAUSE_EN defined: enter press in PLAY SHALL go to PAUSE with game_en=0.
REQ-033 In PAUSE: an enter press SHALL return to PLAY; all other inputs SHALL be ignored; counters SHALL be frozen.
REQ-034 Macro GAME_CTRL_PAUSE_EN undefined: PAUSE SHALL be unreachable and enter SHALL be ignored in PLAY.

Verification (LIFE_INIT=3, BOMB_INIT=3, INIT_WAIT=4, INVULN=8, BOMB=6, CLEAR=5, NUM_STAGES=2)
REQ-035 Reset release, enter held -> START after exactly 4 cycles; no PLAY until enter falls and rises again.
REQ-036 Three collisions, each after invulnerability ends -> num_life 2, 1, 0; the third collision gives GAMEOVER with game_en=0.
REQ-037 Four bomb presses in PLAY, each after BOMB ends -> num_bomb 2, 1, 0; the fourth press is ignored and the state stays PLAY.
REQ-038 die at stage 0 -> CLEAR for 5 cycles, then stage=1, num_bomb=3, one game_reset pulse, PLAY; die again -> SUCCESS.
REQ-039 die and collision in the same PLAY cycle -> CLEAR, num_life unchanged.
REQ-040 With GAME_CTRL_PAUSE_EN: enter during PLAY -> PAUSE and game_en=0; collision is ignored; a second enter returns to PLAY.
